// File: rtl/pcie_layer_loader_pkg.sv
// rtl/pcie_layer_loader_pkg.sv - shared types and defaults for the PCIe layer loader
package pcie_layer_loader_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_CNT_W        = 24;
  localparam int DEF_BIAS_DEPTH   = 4096;
  localparam int DEF_WEIGHT_DEPTH = 1048576;
  localparam int DEF_LAYER_DEPTH  = 262144;

  // Loader FSM encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_BIAS   = 3'd2,
    S_WEIGHT = 3'd3,
    S_DATA   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } loadState_t;

  // Layer codes, same encoding as global_controller
  typedef enum logic [3:0] {
    LYR_IDLE  = 4'd0,
    LYR_CONV1 = 4'd1,
    LYR_CONV2 = 4'd2,
    LYR_CONV3 = 4'd3,
    LYR_CONV4 = 4'd4,
    LYR_CONV5 = 4'd5,
    LYR_POOL1 = 4'd6,
    LYR_POOL2 = 4'd7,
    LYR_POOL5 = 4'd8,
    LYR_FC6   = 4'd9,
    LYR_FC7   = 4'd10,
    LYR_FC8   = 4'd11
  } layer_t;

  // First write phase with a nonzero count, in bias/weight/data order
  function automatic loadState_t firstPhase(input logic biasNz, input logic weightNz,
                                            input logic dataNz);
    if (biasNz)        return S_BIAS;
    else if (weightNz) return S_WEIGHT;
    else if (dataNz)   return S_DATA;
    else               return S_DONE;
  endfunction

endpackage

// File: rtl/pcie_layer_loader_if.sv
// rtl/pcie_layer_loader_if.sv - DMA word stream in, RAM write port out
interface pcie_layer_loader_if
  import pcie_layer_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              biasWrEn;
  logic              weightWrEn;
  logic              layerWrEn;
  logic [CNT_W-1:0]  wrAddr;
  logic [DATA_W-1:0] wrData;

  modport master (
    output s_valid, s_data,
    input  s_ready, biasWrEn, weightWrEn, layerWrEn, wrAddr, wrData
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, biasWrEn, weightWrEn, layerWrEn, wrAddr, wrData
  );
endinterface

// File: rtl/pcie_hdr_parser.sv
// rtl/pcie_hdr_parser.sv - three-beat load header capture with RAM depth check
module pcie_hdr_parser
  import pcie_layer_loader_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int BIAS_DEPTH   = DEF_BIAS_DEPTH,
  parameter int WEIGHT_DEPTH = DEF_WEIGHT_DEPTH,
  parameter int LAYER_DEPTH  = DEF_LAYER_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             beat,
  input  logic [CNT_W-1:0] word,
  output logic [CNT_W-1:0] biasCnt,
  output logic [CNT_W-1:0] weightCnt,
  output logic [CNT_W-1:0] dataCnt,
  output logic             hdrDone,
  output logic             hdrErr
);
  logic [1:0]       beatIdx;
  logic [CNT_W-1:0] dataCntQ;

  // Capture header words in order; beatIdx parks at 3 once the header is complete
  always_ff @(posedge clk) begin
    if (!rst) begin
      beatIdx   <= 2'd0;
      biasCnt   <= '0;
      weightCnt <= '0;
      dataCntQ  <= '0;
    end else if (ena) begin
      if (clear) begin
        beatIdx <= 2'd0;
      end else if (beat && beatIdx != 2'd3) begin
        case (beatIdx)
          2'd0:    biasCnt   <= word;
          2'd1:    weightCnt <= word;
          default: dataCntQ  <= word;
        endcase
        beatIdx <= beatIdx + 2'd1;
      end
    end
  end

  // The data count is live on the third beat so the loader can branch without a bubble
  assign hdrDone = beat && (beatIdx == 2'd2);
  assign dataCnt = (beatIdx == 2'd2) ? word : dataCntQ;
  assign hdrErr  = hdrDone && ((biasCnt > CNT_W'(BIAS_DEPTH)) ||
                               (weightCnt > CNT_W'(WEIGHT_DEPTH)) ||
                               (word > CNT_W'(LAYER_DEPTH)));
endmodule

// File: rtl/pcie_layer_loader.sv
// rtl/pcie_layer_loader.sv - loads bias/weight/layer RAMs from the PCIe DMA stream
module pcie_layer_loader
  import pcie_layer_loader_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int BIAS_DEPTH   = DEF_BIAS_DEPTH,
  parameter int WEIGHT_DEPTH = DEF_WEIGHT_DEPTH,
  parameter int LAYER_DEPTH  = DEF_LAYER_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                pcieCmd,
  input  logic [3:0]          runLayer,
  pcie_layer_loader_if.slave  bus,
  output logic                pcieDataReady,
  output logic [3:0]          loadedLayer,
  output logic                loadErr
);
  loadState_t        state, stateNext;
  logic [CNT_W-1:0]  idx, idxNext;
  logic              biasWrQ, weightWrQ, layerWrQ;
  logic              biasWrN, weightWrN, layerWrN;
  logic [CNT_W-1:0]  wrAddrQ, wrAddrN;
  logic [DATA_W-1:0] wrDataQ, wrDataN;
  logic              readyN, loadErrN;
  logic [3:0]        loadedN;
  logic [CNT_W-1:0]  biasCnt, weightCnt, dataCnt;
  logic              hdrDone, hdrErr;
  logic              sReady, beat;

  assign sReady = ena && (state == S_HDR || state == S_BIAS ||
                          state == S_WEIGHT || state == S_DATA);
  assign beat   = bus.s_valid && sReady;

  pcie_hdr_parser #(
    .CNT_W(CNT_W), .BIAS_DEPTH(BIAS_DEPTH),
    .WEIGHT_DEPTH(WEIGHT_DEPTH), .LAYER_DEPTH(LAYER_DEPTH)
  ) u_hdr (
    .clk(clk), .rst(rst), .ena(ena),
    .clear(state == S_IDLE),
    .beat(beat && state == S_HDR),
    .word(bus.s_data[CNT_W-1:0]),
    .biasCnt(biasCnt), .weightCnt(weightCnt), .dataCnt(dataCnt),
    .hdrDone(hdrDone), .hdrErr(hdrErr)
  );

  // State register; ena low freezes the load in place
  always_ff @(posedge clk) begin
    if (!rst)     state <= S_IDLE;
    else if (ena) state <= stateNext;
  end

  // Next state, phase index and the registered write port contents
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    biasWrN   = 1'b0;
    weightWrN = 1'b0;
    layerWrN  = 1'b0;
    wrAddrN   = wrAddrQ;
    wrDataN   = wrDataQ;
    readyN    = 1'b0;
    loadedN   = loadedLayer;
    loadErrN  = loadErr;
    case (state)
      S_IDLE: if (pcieCmd && !pcieDataReady) begin
        loadedN   = runLayer;
        stateNext = S_HDR;
      end
      S_HDR: if (hdrDone) begin
        idxNext = '0;
        if (hdrErr) begin
          stateNext = S_ERR;
          loadErrN  = 1'b1;
        end else begin
          stateNext = firstPhase(biasCnt != '0, weightCnt != '0, dataCnt != '0);
        end
      end
      S_BIAS: if (beat) begin
        biasWrN = 1'b1;
        wrAddrN = idx;
        wrDataN = bus.s_data;
        if (idx == biasCnt - CNT_W'(1)) begin
          idxNext   = '0;
          stateNext = firstPhase(1'b0, weightCnt != '0, dataCnt != '0);
        end else begin
          idxNext = idx + CNT_W'(1);
        end
      end
      S_WEIGHT: if (beat) begin
        weightWrN = 1'b1;
        wrAddrN   = idx;
        wrDataN   = bus.s_data;
        if (idx == weightCnt - CNT_W'(1)) begin
          idxNext   = '0;
          stateNext = firstPhase(1'b0, 1'b0, dataCnt != '0);
        end else begin
          idxNext = idx + CNT_W'(1);
        end
      end
      S_DATA: if (beat) begin
        layerWrN = 1'b1;
        wrAddrN  = idx;
        wrDataN  = bus.s_data;
        if (idx == dataCnt - CNT_W'(1)) begin
          idxNext   = '0;
          stateNext = S_DONE;
        end else begin
          idxNext = idx + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Ready rises one cycle after entry and drops once the controller releases pcieCmd
        readyN = !(!pcieCmd && pcieDataReady);
        if (!pcieCmd && pcieDataReady) stateNext = S_IDLE;
      end
      S_ERR: ;
      default: stateNext = S_IDLE;
    endcase
  end

  // Datapath and status registers, held while ena is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx           <= '0;
      biasWrQ       <= 1'b0;
      weightWrQ     <= 1'b0;
      layerWrQ      <= 1'b0;
      wrAddrQ       <= '0;
      wrDataQ       <= '0;
      pcieDataReady <= 1'b0;
      loadedLayer   <= 4'd0;
      loadErr       <= 1'b0;
    end else if (ena) begin
      idx           <= idxNext;
      biasWrQ       <= biasWrN;
      weightWrQ     <= weightWrN;
      layerWrQ      <= layerWrN;
      wrAddrQ       <= wrAddrN;
      wrDataQ       <= wrDataN;
      pcieDataReady <= readyN;
      loadedLayer   <= loadedN;
      loadErr       <= loadErrN;
    end
  end

  // A write pending when ena drops is masked, not lost; it issues once ena returns
  assign bus.s_ready    = sReady;
  assign bus.biasWrEn   = biasWrQ && ena;
  assign bus.weightWrEn = weightWrQ && ena;
  assign bus.layerWrEn  = layerWrQ && ena;
  assign bus.wrAddr     = wrAddrQ;
  assign bus.wrData     = wrDataQ;
endmodule

// File: tb/tb_pcie_layer_loader.sv
// tb/tb_pcie_layer_loader.sv - self-checking bench for pcie_layer_loader
module tb_pcie_layer_loader;
  localparam int BIAS_DEPTH   = 4096;
  localparam int WEIGHT_DEPTH = 1048576;
  localparam int LAYER_DEPTH  = 262144;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       pcieCmd;
  logic [3:0] runLayer;
  logic       pcieDataReady;
  logic [3:0] loadedLayer;
  logic       loadErr;

  pcie_layer_loader_if #(.DATA_W(32), .CNT_W(24)) bus ();

  pcie_layer_loader dut (
    .clk(clk), .rst(rst), .ena(ena), .pcieCmd(pcieCmd), .runLayer(runLayer),
    .bus(bus), .pcieDataReady(pcieDataReady), .loadedLayer(loadedLayer),
    .loadErr(loadErr)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          ram;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          nChecks = 0;
  int          nFail = 0;
  int          wrCnt[3];
  int          snap[3];
  int          lastAddr[3];
  logic [31:0] lastData[3];
  bit          simDone = 1'b0;
  int          viol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: header counts plus sequential word values give the ordered write list
  task automatic modelLoad(input int b, input int w, input int d, input int base);
    int k = 0;
    if (b > BIAS_DEPTH || w > WEIGHT_DEPTH || d > LAYER_DEPTH) return;
    for (int i = 0; i < b; i++) begin expQ.push_back('{ram: 0, addr: i, data: base + k}); k++; end
    for (int i = 0; i < w; i++) begin expQ.push_back('{ram: 1, addr: i, data: base + k}); k++; end
    for (int i = 0; i < d; i++) begin expQ.push_back('{ram: 2, addr: i, data: base + k}); k++; end
  endtask

  task automatic takeSnap();
    for (int i = 0; i < 3; i++) snap[i] = wrCnt[i];
  endtask

  task automatic sendWord(input logic [31:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.s_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.s_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic waitReady();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pcieDataReady === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin wrCnt[i] = 0; lastAddr[i] = -1; lastData[i] = '0; end
    fork
      // Compare process: every RAM write must match the head of the model queue
      begin
        while (!simDone) begin
          int n;
          int ram;
          wr_t e;
          @(negedge clk);
          n = int'(bus.biasWrEn === 1'b1) + int'(bus.weightWrEn === 1'b1) +
              int'(bus.layerWrEn === 1'b1);
          if (n > 0) begin
            chk("one_wren", n, 1);
            ram = (bus.biasWrEn === 1'b1) ? 0 : (bus.weightWrEn === 1'b1) ? 1 : 2;
            if (expQ.size() == 0) begin
              chk("unexpected_write_ram", ram, 99);
            end else begin
              e = expQ.pop_front();
              chk("wr_ram", ram, e.ram);
              chk("wr_addr", bus.wrAddr, e.addr);
              chk("wr_data", bus.wrData, e.data);
            end
            wrCnt[ram]++;
            lastAddr[ram] = int'(bus.wrAddr);
            lastData[ram] = bus.wrData;
          end
        end
      end
      begin
        rst = 1'b0; ena = 1'b1; pcieCmd = 1'b0; runLayer = 4'd0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_ready", pcieDataReady, 0);
        chk("rst_loadErr", loadErr, 0);
        chk("rst_loadedLayer", loadedLayer, 0);
        chk("rst_wrAddr", bus.wrAddr, 0);
        chk("rst_wrData", bus.wrData, 0);
        chk("rst_wren", {bus.biasWrEn, bus.weightWrEn, bus.layerWrEn}, 0);
        rst = 1'b1;

        // Nominal load: header (2,3,4), words 0x100..0x108
        modelLoad(2, 3, 4, 32'h100);
        takeSnap();
        pcieCmd = 1'b1; runLayer = 4'd0;
        sendWord(2); sendWord(3); sendWord(4);
        for (int k = 0; k < 9; k++) sendWord(32'h100 + k);
        @(negedge clk);
        chk("nom_last_write", bus.layerWrEn, 1);
        chk("nom_ready_with_write", pcieDataReady, 0);
        @(negedge clk);
        chk("nom_ready_after", pcieDataReady, 1);
        chk("nom_loadedLayer", loadedLayer, 0);
        chk("nom_bias_n", wrCnt[0] - snap[0], 2);
        chk("nom_weight_n", wrCnt[1] - snap[1], 3);
        chk("nom_layer_n", wrCnt[2] - snap[2], 4);
        chk("nom_bias_last_addr", lastAddr[0], 1);
        chk("nom_bias_last_data", lastData[0], 32'h101);
        chk("nom_weight_last", {lastAddr[1], lastData[1]}, {32'd2, 32'h104});
        chk("nom_layer_last", {lastAddr[2], lastData[2]}, {32'd3, 32'h108});
        chk("nom_queue_empty", expQ.size(), 0);

        // Release and restart with runLayer=1
        pcieCmd = 1'b0;
        @(negedge clk);
        chk("rel_ready_low", pcieDataReady, 0);
        pcieCmd = 1'b1; runLayer = 4'd1;
        @(negedge clk);
        chk("rel_loadedLayer", loadedLayer, 1);
        chk("rel_s_ready", bus.s_ready, 1);

        // Zero-count skip with stalls: header (0,0,5)
        modelLoad(0, 0, 5, 32'h200);
        takeSnap();
        sendWord(0); sendWord(0); sendWord(5);
        for (int k = 0; k < 5; k++) begin
          repeat (2) @(negedge clk);
          sendWord(32'h200 + k);
        end
        waitReady();
        chk("skip_bias_n", wrCnt[0] - snap[0], 0);
        chk("skip_weight_n", wrCnt[1] - snap[1], 0);
        chk("skip_layer_n", wrCnt[2] - snap[2], 5);
        chk("skip_layer_last", {lastAddr[2], lastData[2]}, {32'd4, 32'h204});
        chk("skip_queue_empty", expQ.size(), 0);
        pcieCmd = 1'b0;
        repeat (2) @(negedge clk);
        chk("skip_rel_ready", pcieDataReady, 0);

        // Overflow: biasCnt = BIAS_DEPTH+1
        pcieCmd = 1'b1; runLayer = 4'd2;
        modelLoad(BIAS_DEPTH + 1, 0, 0, 32'h0);
        sendWord(BIAS_DEPTH + 1); sendWord(0); sendWord(0);
        bus.s_valid = 1'b1; bus.s_data = 32'h5a5a;
        @(negedge clk);
        chk("ovf_loadErr", loadErr, 1);
        chk("ovf_s_ready", bus.s_ready, 0);
        viol = 0;
        repeat (100) begin
          @(negedge clk);
          if (loadErr !== 1'b1 || bus.s_ready !== 1'b0 || pcieDataReady !== 1'b0) viol++;
        end
        chk("ovf_hold_100", viol, 0);
        rst = 1'b0; pcieCmd = 1'b0; bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_rst_loadErr", loadErr, 0);
        chk("ovf_rst_s_ready", bus.s_ready, 0);
        chk("ovf_rst_loadedLayer", loadedLayer, 0);
        rst = 1'b1;

        // Enable freeze inside WEIGHT: header (0,6,0)
        pcieCmd = 1'b1; runLayer = 4'd5;
        modelLoad(0, 6, 0, 32'h300);
        takeSnap();
        sendWord(0); sendWord(6); sendWord(0);
        sendWord(32'h300); sendWord(32'h301);
        ena = 1'b0; bus.s_valid = 1'b1; bus.s_data = 32'hdead;
        viol = 0;
        repeat (10) begin
          @(negedge clk);
          if (bus.s_ready !== 1'b0 || bus.biasWrEn !== 1'b0 ||
              bus.weightWrEn !== 1'b0 || bus.layerWrEn !== 1'b0) viol++;
          @(posedge clk);
        end
        #1 ena = 1'b1; bus.s_valid = 1'b0;
        chk("frz_quiet", viol, 0);
        for (int k = 2; k < 6; k++) sendWord(32'h300 + k);
        waitReady();
        chk("frz_weight_n", wrCnt[1] - snap[1], 6);
        chk("frz_weight_last", {lastAddr[1], lastData[1]}, {32'd5, 32'h305});
        chk("frz_loadedLayer", loadedLayer, 5);
        chk("frz_queue_empty", expQ.size(), 0);
        pcieCmd = 1'b0;
        repeat (2) @(negedge clk);

        // Reset inside DATA, then a fresh load from the header
        pcieCmd = 1'b1; runLayer = 4'd3;
        modelLoad(1, 1, 4, 32'h400);
        sendWord(1); sendWord(1); sendWord(4);
        sendWord(32'h400); sendWord(32'h401); sendWord(32'h402); sendWord(32'h403);
        rst = 1'b0; pcieCmd = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_wren", {bus.biasWrEn, bus.weightWrEn, bus.layerWrEn}, 0);
        chk("mid_rst_wrAddr", bus.wrAddr, 0);
        chk("mid_rst_wrData", bus.wrData, 0);
        chk("mid_rst_ready", pcieDataReady, 0);
        chk("mid_rst_loadedLayer", loadedLayer, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_pending", expQ.size(), 2);
        expQ.delete();
        rst = 1'b1;
        pcieCmd = 1'b1; runLayer = 4'd4;
        modelLoad(1, 0, 2, 32'h500);
        takeSnap();
        sendWord(1); sendWord(0); sendWord(2);
        for (int k = 0; k < 3; k++) sendWord(32'h500 + k);
        waitReady();
        chk("reload_loadedLayer", loadedLayer, 4);
        chk("reload_bias_n", wrCnt[0] - snap[0], 1);
        chk("reload_layer_n", wrCnt[2] - snap[2], 2);
        chk("reload_layer_last", {lastAddr[2], lastData[2]}, {32'd1, 32'h502});
        chk("reload_queue_empty", expQ.size(), 0);
        simDone = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
